// File: rtl/mod19_sq_accumulator.sv
// Frame accumulator for mod-19 square residues: sums FRAME_LEN accepted samples mod MOD
// and holds each frame result behind a valid/ready handshake.
module mod19_sq_accumulator #(
  parameter int unsigned MOD       = 19,
  parameter int unsigned W         = 5,
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned CW        = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] sq_neg,
  input  logic [W-1:0] sq_pos,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         clear,
  output logic [W-1:0] out_sum,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);

  localparam logic [W-1:0]  MODR = W'(MOD);
  localparam logic [W:0]    MODW = (W+1)'(MOD);
  localparam logic [CW-1:0] LAST = CW'(FRAME_LEN - 1);

  typedef enum logic {ACC, HOLD} state_t;

  state_t        state, state_n;
  logic [W-1:0]  acc, acc_n, out_sum_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          out_valid_n, err_n;
  logic [W-1:0]  res, res_adj, acc_add;
  logic [W:0]    s;
  logic          res_bad;

  // Out-of-range residues (max 31) fold back with a single subtraction.
  always_comb begin
    res     = sq_neg | sq_pos;
    res_bad = (res >= MODR);
    res_adj = res_bad ? (res - MODR) : res;
    s       = {1'b0, acc} + {1'b0, res_adj};
    acc_add = (s >= MODW) ? W'(s - MODW) : s[W-1:0];
  end

  always_comb begin
    state_n     = state;
    acc_n       = acc;
    cnt_n       = cnt;
    out_sum_n   = out_sum;
    out_valid_n = out_valid;
    err_n       = err;
    if (clear) begin
      state_n     = ACC;
      acc_n       = '0;
      cnt_n       = '0;
      out_valid_n = 1'b0;
      err_n       = 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            err_n = err | res_bad;
            if (cnt == LAST) begin
              out_sum_n   = acc_add;
              out_valid_n = 1'b1;
              acc_n       = '0;
              cnt_n       = '0;
              state_n     = HOLD;
            end else begin
              acc_n = acc_add;
              cnt_n = cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_n = 1'b0;
            state_n     = ACC;
          end
        end
        default: state_n = ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      out_sum   <= '0;
      out_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_n;
      acc       <= acc_n;
      cnt       <= cnt_n;
      out_sum   <= out_sum_n;
      out_valid <= out_valid_n;
      err       <= err_n;
    end
  end

  assign in_ready = (state == ACC);

endmodule

// File: tb/tb_mod19_sq_accumulator.sv
// Directed bench for mod19_sq_accumulator: default 8-sample frames plus a FRAME_LEN=1 instance.
module tb_mod19_sq_accumulator;

  logic       clk = 1'b0;
  logic       rst, in_valid, clear, out_ready;
  logic [4:0] sq_neg, sq_pos, out_sum;
  logic       in_ready, out_valid, err;

  logic       v1, r1;
  logic [4:0] n1, p1, os1;
  logic       ir1, ov1, e1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  mod19_sq_accumulator #(.MOD(19), .W(5), .FRAME_LEN(8), .CW(8)) dut (
    .clk(clk), .rst(rst), .sq_neg(sq_neg), .sq_pos(sq_pos), .in_valid(in_valid),
    .in_ready(in_ready), .clear(clear), .out_sum(out_sum), .out_valid(out_valid),
    .out_ready(out_ready), .err(err)
  );

  mod19_sq_accumulator #(.MOD(19), .W(5), .FRAME_LEN(1), .CW(8)) dut1 (
    .clk(clk), .rst(rst), .sq_neg(n1), .sq_pos(p1), .in_valid(v1),
    .in_ready(ir1), .clear(1'b0), .out_sum(os1), .out_valid(ov1),
    .out_ready(r1), .err(e1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [4:0] neg, input logic [4:0] pos);
    in_valid = 1'b1;
    sq_neg   = neg;
    sq_pos   = pos;
    step();
    in_valid = 1'b0;
    sq_neg   = '0;
    sq_pos   = '0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; clear = 1'b0; out_ready = 1'b1;
    sq_neg = '0; sq_pos = '0;
    v1 = 1'b0; r1 = 1'b1; n1 = '0; p1 = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_err", 32'(err), 0);

    // T1: 8 x 6 -> 48 mod 19 = 10
    for (int i = 0; i < 7; i++) send(5'd0, 5'd6);
    chk("t1_not_yet", 32'(out_valid), 0);
    send(5'd0, 5'd6);
    chk("t1_valid", 32'(out_valid), 1);
    chk("t1_sum", 32'(out_sum), 10);
    chk("t1_err", 32'(err), 0);
    chk("t1_in_ready_hold", 32'(in_ready), 0);
    step();
    chk("t1_valid_drop", 32'(out_valid), 0);
    chk("t1_in_ready_back", 32'(in_ready), 1);

    // T2: 8 x 18 -> 144 mod 19 = 11
    for (int i = 0; i < 8; i++) send(5'd18, 5'd0);
    chk("t2_valid", 32'(out_valid), 1);
    chk("t2_sum", 32'(out_sum), 11);
    step();

    // T3: backpressure on a frame of 8 x 1 -> 8
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(5'd0, 5'd1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; sq_pos = 5'd5;
      chk("t3_in_ready", 32'(in_ready), 0);
      step();
      chk("t3_valid", 32'(out_valid), 1);
      chk("t3_sum", 32'(out_sum), 8);
    end
    in_valid = 1'b0; sq_pos = '0;
    out_ready = 1'b1;
    step();
    chk("t3_released", 32'(out_valid), 0);
    for (int i = 0; i < 8; i++) send(5'd0, 5'd2);
    chk("t3_next_sum", 32'(out_sum), 16);
    step();

    // T4: 25 folds to 6 and sets err
    send(5'd0, 5'd25);
    chk("t4_err_set", 32'(err), 1);
    for (int i = 0; i < 7; i++) send(5'd0, 5'd0);
    chk("t4_sum", 32'(out_sum), 6);
    step();
    chk("t4_err_sticky", 32'(err), 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("t4_err_cleared", 32'(err), 0);

    // T5: partial frame of 9s discarded by clear; the sample during clear is dropped
    for (int i = 0; i < 3; i++) send(5'd0, 5'd9);
    clear = 1'b1; in_valid = 1'b1; sq_pos = 5'd9;
    step();
    clear = 1'b0; in_valid = 1'b0; sq_pos = '0;
    chk("t5_clear_valid", 32'(out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      send(5'd0, 5'd1);
      chk("t5_pulse", 32'(out_valid), (i == 7) ? 1 : 0);
    end
    chk("t5_sum", 32'(out_sum), 8);
    step();
    chk("t5_single", 32'(out_valid), 0);

    // T6: reset at cnt=4 (err set) and again in HOLD
    send(5'd0, 5'd4); send(5'd0, 5'd20); send(5'd0, 5'd4); send(5'd0, 5'd4);
    chk("t6_err_pre", 32'(err), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6a_err", 32'(err), 0);
    chk("t6a_valid", 32'(out_valid), 0);
    chk("t6a_in_ready", 32'(in_ready), 1);
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(5'd0, 5'd3);
    chk("t6_hold_sum", 32'(out_sum), 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    chk("t6b_valid", 32'(out_valid), 0);
    chk("t6b_sum", 32'(out_sum), 0);
    chk("t6b_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 8; i++) send(5'd0, 5'd4);
    chk("t6_sum", 32'(out_sum), 13);
    chk("t6_valid", 32'(out_valid), 1);
    step();

    // FRAME_LEN=1: each accepted sample is a result
    v1 = 1'b1; p1 = 5'd25;
    step();
    chk("f1_valid", 32'(ov1), 1);
    chk("f1_sum", 32'(os1), 6);
    chk("f1_err", 32'(e1), 1);
    chk("f1_in_ready", 32'(ir1), 0);
    p1 = 5'd7;
    step();
    chk("f1_handshake", 32'(ov1), 0);
    chk("f1_ready_back", 32'(ir1), 1);
    step();
    v1 = 1'b0; p1 = '0;
    chk("f1_sum2", 32'(os1), 7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
